// File: rtl/grid_pkg.sv
// Shared definitions for the paper-grid loader: character codes, FSM state
// encodings and the character classes produced by the byte classifier.
package grid_pkg;

  localparam logic [7:0] CH_PAPER = 8'h40;
  localparam logic [7:0] CH_EMPTY = 8'h2E;
  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_EOT   = 8'h04;

  typedef logic [1:0] state_t;
  localparam state_t LOAD  = 2'd0;
  localparam state_t DRAIN = 2'd1;
  localparam state_t DONE  = 2'd2;

  typedef enum logic [2:0] {
    PAPER,
    EMPTY,
    NL,
    CR,
    EOT,
    ILLEGAL
  } char_class_t;

endpackage

// File: rtl/grid_char_classify.sv
// Maps one incoming ASCII byte onto the loader's character class.
module grid_char_classify
  import grid_pkg::*;
(
  input  logic [7:0]  in_data,
  output char_class_t cls
);

  always_comb begin
    // NOTE: the default arm assigns cls on every path; leaving a code
    // unassigned would infer a latch instead of pure logic.
    case (in_data)
      CH_PAPER: cls = PAPER;
      CH_EMPTY: cls = EMPTY;
      CH_NL:    cls = NL;
      CH_CR:    cls = CR;
      CH_EOT:   cls = EOT;
      default:  cls = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/grid_loader.sv
// Assembles a packed occupancy grid from a puzzle byte stream and hands the
// finished grid, its dimensions, paper count and error flag to the consumer.
module grid_loader
  import grid_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  input  logic [7:0]                         in_data,
  output logic                               in_ready,
  output logic [WIDTH*DEPTH-1:0]             grid_out,
  output logic                               grid_valid,
  input  logic                               grid_ready,
  output logic [$clog2(DEPTH+1)-1:0]         rows,
  output logic [$clog2(WIDTH+1)-1:0]         cols,
  output logic [$clog2(WIDTH*DEPTH+1)-1:0]   paper_count,
  output logic                               error
);

  localparam int ROW_W = $clog2(DEPTH + 1);
  localparam int COL_W = $clog2(WIDTH + 1);
  localparam int CNT_W = $clog2(WIDTH * DEPTH + 1);
  localparam int IDX_W = $clog2(WIDTH * DEPTH);

  state_t             state_q;
  logic               live_q;
  logic [COL_W-1:0]   col_q;
  logic               dirty_q;   // current line holds a non-CR byte
  char_class_t        cls;
  logic               accept;
  logic               first_row;
  logic               len_bad;
  logic               last_row;
  logic               col_full;
  logic [IDX_W-1:0]   cell_idx;

  grid_char_classify u_classify (
    .in_data (in_data),
    .cls     (cls)
  );

  // in_ready stays low while in reset and until the first clock after release.
  assign in_ready   = live_q && (state_q != DONE);
  assign grid_valid = (state_q == DONE);
  assign accept     = in_valid && in_ready;

  assign first_row  = (rows == '0);
  assign len_bad    = !first_row && (col_q != cols);
  assign last_row   = (rows == ROW_W'(DEPTH - 1));
  assign col_full   = (col_q == COL_W'(WIDTH));
  assign cell_idx   = IDX_W'(int'(rows) * WIDTH + int'(col_q));

  // NOTE: every register here uses <= so all updates take effect together at
  // the clock edge, independent of statement order within the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      live_q      <= 1'b0;
      col_q       <= '0;
      dirty_q     <= 1'b0;
      // NOTE: the grid is a flop array rather than RAM, and it must read as
      // zero beyond the loaded area, so it is reset and cleared explicitly.
      grid_out    <= '0;
      rows        <= '0;
      cols        <= '0;
      paper_count <= '0;
      error       <= 1'b0;
    end else begin
      live_q <= 1'b1;
      case (state_q)
        LOAD: if (accept) begin
          case (cls)
            PAPER, EMPTY: begin
              dirty_q <= 1'b1;
              if (col_full) begin
                error   <= 1'b1;
                state_q <= DRAIN;
              end else begin
                grid_out[cell_idx] <= (cls == PAPER);
                col_q              <= col_q + COL_W'(1);
                if (cls == PAPER) paper_count <= paper_count + CNT_W'(1);
              end
            end
            NL: begin
              dirty_q <= 1'b0;
              col_q   <= '0;
              if (col_q == '0) begin
                state_q <= DONE;
              end else if (len_bad) begin
                error   <= 1'b1;
                state_q <= DRAIN;
              end else begin
                rows <= rows + ROW_W'(1);
                if (first_row) cols <= col_q;
                if (last_row) state_q <= DONE;
              end
            end
            EOT: begin
              dirty_q <= 1'b0;
              col_q   <= '0;
              state_q <= DONE;
              if (col_q != '0) begin
                if (len_bad) begin
                  error <= 1'b1;
                end else begin
                  rows <= rows + ROW_W'(1);
                  if (first_row) cols <= col_q;
                end
              end
            end
            CR: begin
            end
            default: begin
              dirty_q <= 1'b1;
              error   <= 1'b1;
              state_q <= DRAIN;
            end
          endcase
        end

        // Swallow the rest of a malformed grid up to its terminator.
        DRAIN: if (accept) begin
          case (cls)
            NL: begin
              dirty_q <= 1'b0;
              if (!dirty_q) state_q <= DONE;
            end
            EOT: begin
              dirty_q <= 1'b0;
              state_q <= DONE;
            end
            CR: begin
            end
            default: dirty_q <= 1'b1;
          endcase
        end

        DONE: if (grid_ready) begin
          state_q     <= LOAD;
          col_q       <= '0;
          dirty_q     <= 1'b0;
          grid_out    <= '0;
          rows        <= '0;
          cols        <= '0;
          paper_count <= '0;
          error       <= 1'b0;
        end

        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_loader.sv
// Self-checking bench for grid_loader (4x4): hand-written vector table,
// reset and hold sequences, and random streams against a line-level model.
module tb_grid_loader;

  localparam int W = 4;
  localparam int D = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [W*D-1:0]    grid_out;
  logic              grid_valid;
  logic              grid_ready;
  logic [2:0]        rows;
  logic [2:0]        cols;
  logic [4:0]        paper_count;
  logic              error;

  int n_checks = 0;
  int n_fail   = 0;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [W*D-1:0] grid;
    int             rows;
    int             cols;
    int             cnt;
    bit             err;
    int             used;
  } exp_t;

  typedef struct {
    logic [W*D-1:0] grid;
    int             rows;
    int             cols;
    int             cnt;
    bit             err;
  } obs_t;

  typedef struct {
    string          text;
    int             rows;
    int             cols;
    int             cnt;
    bit             err;
    logic [W*D-1:0] grid;
    bit             rdy;
    int             hold;
    bit             gaps;
  } vec_t;

  grid_loader #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .grid_out    (grid_out),
    .grid_valid  (grid_valid),
    .grid_ready  (grid_ready),
    .rows        (rows),
    .cols        (cols),
    .paper_count (paper_count),
    .error       (error)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Table text uses '~' for EOT and '^' for carriage return.
  function automatic bq_t to_q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "~")      q.push_back(8'h04);
      else if (s[i] == "^") q.push_back(8'h0D);
      else                  q.push_back(s[i]);
    end
    return q;
  endfunction

  // Line-level reference: walks the text, tracking the current line length
  // and whether the stream is being discarded after a fault.
  function automatic exp_t model(input bq_t s);
    exp_t e;
    int   col   = 0;
    int   raw   = 0;
    bit   drain = 0;
    e = '{grid: '0, rows: 0, cols: 0, cnt: 0, err: 0, used: s.size()};
    for (int k = 0; k < s.size(); k++) begin
      logic [7:0] c = s[k];
      bit term = 0;
      if (c == 8'h0D) continue;
      if (drain) begin
        if (c == 8'h04 || (c == 8'h0A && raw == 0)) term = 1;
        raw = (c == 8'h0A) ? 0 : raw + 1;
      end else if (c == 8'h40 || c == 8'h2E) begin
        raw++;
        if (col == W) begin
          e.err = 1;
          drain = 1;
        end else begin
          e.grid[e.rows * W + col] = (c == 8'h40);
          if (c == 8'h40) e.cnt++;
          col++;
        end
      end else if (c == 8'h0A || c == 8'h04) begin
        if (col == 0) begin
          term = 1;
        end else begin
          if (e.rows > 0 && col != e.cols) begin
            e.err = 1;
            if (c == 8'h0A) drain = 1;
          end else begin
            if (e.rows == 0) e.cols = col;
            e.rows++;
            if (e.rows == D) term = 1;
          end
          if (c == 8'h04) term = 1;
        end
        col = 0;
        raw = 0;
      end else begin
        e.err = 1;
        drain = 1;
        raw++;
      end
      if (term) begin
        e.used = k + 1;
        return e;
      end
    end
    return e;
  endfunction

  function automatic bq_t rand_stream();
    bq_t q;
    int  nl = $urandom_range(0, 5);
    int  w0 = $urandom_range(1, 4);
    for (int r = 0; r < nl; r++) begin
      int len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : w0;
      for (int j = 0; j < len; j++) begin
        int p = $urandom_range(0, 19);
        if (p < 9)        q.push_back(8'h40);
        else if (p < 18)  q.push_back(8'h2E);
        else if (p == 18) q.push_back(8'h0D);
        else              q.push_back(8'h41 + 8'($urandom_range(0, 20)));
      end
      q.push_back(8'h0A);
    end
    case ($urandom_range(0, 2))
      0: q.push_back(8'h0A);
      1: q.push_back(8'h04);
      default: begin
        if (q.size() > 0) void'(q.pop_back());
        q.push_back(8'h04);
      end
    endcase
    return q;
  endfunction

  // Feeds one grid, checks terminator-to-grid_valid latency, optionally holds
  // grid_ready low, then performs the handshake and checks the clear.
  task automatic run_grid(input string name, input bq_t s, input bit gaps,
                          input bit rdy, input int hold, output obs_t o);
    exp_t       m = model(s);
    int         i = 0;
    int         cyc = 0;
    bit         seen = 0;
    bit         lat_ok = 1;
    bit         acc;
    logic [28:0] snap;
    grid_ready = rdy;
    while (!seen) begin
      @(negedge clk);
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = (i < s.size()) ? s[i] : 8'h04;
      #1 acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) i++;
      #1;
      if (grid_valid) seen = 1;
      if (grid_valid !== (i == m.used)) lat_ok = 0;
      cyc++;
      if (cyc > 300) break;
    end
    check({name, " grid_valid seen"}, seen, 1);
    check({name, " latency"}, lat_ok, 1);
    o = '{grid: grid_out, rows: int'(rows), cols: int'(cols),
          cnt: int'(paper_count), err: error};
    snap = {grid_out, rows, cols, paper_count, error, grid_valid};
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      grid_ready = 1'b0;
      in_valid   = 1'b1;
      in_data    = 8'h40;
      #1 check({name, " hold in_ready"}, in_ready, 0);
      @(posedge clk);
      #1 check({name, " hold outputs"}, {grid_out, rows, cols, paper_count, error, grid_valid}, snap);
    end
    @(negedge clk);
    grid_ready = 1'b1;
    in_valid   = 1'b1;
    in_data    = 8'h40;
    #1 check({name, " handshake in_ready"}, in_ready, 0);
    @(posedge clk);
    #1 check({name, " cleared"}, {grid_out, rows, cols, paper_count, error, grid_valid, in_ready},
             {29'd0, 1'b1});
    @(negedge clk);
    grid_ready = 1'b0;
    in_valid   = 1'b0;
  endtask

  task automatic compare(input string name, input obs_t o, input int r, input int c,
                         input int n, input bit e, input logic [W*D-1:0] g);
    check({name, " rows"}, o.rows, r);
    check({name, " cols"}, o.cols, c);
    check({name, " paper_count"}, o.cnt, n);
    check({name, " error"}, o.err, e);
    check({name, " grid"}, o.grid, g);
  endtask

  vec_t vecs[10];

  initial begin
    obs_t o;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    grid_ready = 1'b0;

    vecs[0] = '{"@@.@\n.@@.\n@...\n@@@@\n", 4, 4, 10, 0, 16'hF16B, 1, 0, 0};
    vecs[1] = '{"@.\n.@\n\n",               2, 2, 2,  0, 16'h0021, 0, 0, 1};
    vecs[2] = '{"@@@\n@@\n@.x\n~",          1, 3, 5,  1, 16'h0037, 0, 5, 0};
    vecs[3] = '{"@x@\n~",                   0, 0, 1,  1, 16'h0001, 0, 0, 1};
    vecs[4] = '{"@@@@@\n\n",                0, 0, 4,  1, 16'h000F, 0, 0, 0};
    vecs[5] = '{"~",                        0, 0, 0,  0, 16'h0000, 1, 0, 0};
    vecs[6] = '{"@.@^\n.@.^\n~",            2, 3, 3,  0, 16'h0025, 0, 0, 1};
    vecs[7] = '{"@@\n.@~",                  2, 2, 3,  0, 16'h0023, 0, 0, 0};
    vecs[8] = '{"@@\n@~",                   1, 2, 3,  1, 16'h0013, 0, 2, 0};
    vecs[9] = '{"\n",                       0, 0, 0,  0, 16'h0000, 1, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", in_ready, 0);
    check("reset outputs", {grid_out, rows, cols, paper_count, error, grid_valid}, 29'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("release in_ready before clk", in_ready, 0);
    @(posedge clk);
    #1 check("release in_ready after clk", in_ready, 1);

    for (int v = 0; v < 10; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      run_grid(nm, to_q(vecs[v].text), vecs[v].gaps, vecs[v].rdy, vecs[v].hold, o);
      compare(nm, o, vecs[v].rows, vecs[v].cols, vecs[v].cnt, vecs[v].err, vecs[v].grid);
    end

    // Reset in the middle of a row discards the partial grid at once.
    repeat (2) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h40;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("pre-reset partial grid", {grid_out, paper_count}, {16'h0003, 5'd2});
    #2 rst_n = 1'b0;
    #1;
    check("mid-row reset outputs", {grid_out, rows, cols, paper_count, error, grid_valid}, 29'd0);
    check("mid-row reset in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("post-reset in_ready", in_ready, 1);
    run_grid("post-reset", to_q("@\n~"), 0, 0, 0, o);
    compare("post-reset", o, 1, 1, 1, 0, 16'h0001);

    for (int t = 0; t < 40; t++) begin
      bq_t  s = rand_stream();
      exp_t m = model(s);
      string nm;
      nm = $sformatf("rand%0d", t);
      run_grid(nm, s, 1, $urandom_range(0, 1), $urandom_range(0, 2), o);
      compare(nm, o, m.rows, m.cols, m.cnt, m.err, m.grid);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_loader.md
Name: grid_loader

Overview:
- Writer side of the paper-grid datapath: accepts the puzzle text as a byte stream and assembles the packed occupancy matrix (1 = paper, 0 = empty).
- Presents the completed matrix to the accessibility/removal engines through a valid/ready handshake.
- Checks row-length consistency and character legality.
- Reports grid dimensions and total paper count alongside the matrix.

Parameters:
- WIDTH, 16, maximum columns per row
- DEPTH, 16, maximum rows per grid

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  byte on in_data valid
- in_data  in  8  ASCII character
- in_ready  out  1  loader can accept a byte
- grid_out  out  WIDTH*DEPTH  packed row-major grid; row r = bits [r*WIDTH +: WIDTH], column j = bit j of that slice
- grid_valid  out  1  grid_out and status outputs stable and complete
- grid_ready  in  1  consumer accepts grid
- rows  out  $clog2(DEPTH+1)  rows loaded
- cols  out  $clog2(WIDTH+1)  row length, taken from the first row
- paper_count  out  $clog2(WIDTH*DEPTH+1)  number of '@' cells loaded
- error  out  1  malformed input seen for this grid; valid while grid_valid

Behaviour:
- Character map:
  - '@' (0x40) writes 1 at (row, col); col++; paper_count++.
  - '.' (0x2E) writes 0; col++.
  - '\n' (0x0A) ends the row.
  - '\r' (0x0D) is ignored.
  - EOT (0x04) ends the grid.
  - Any other byte is illegal.
- Byte transfer occurs only when in_valid && in_ready. in_data is ignored otherwise.
- States: LOAD, DRAIN, DONE.
- Reset (async, rst_n=0):
  - state = LOAD; grid_out = 0; rows = 0; cols = 0; paper_count = 0; error = 0; grid_valid = 0; in_ready = 0 while rst_n is low.
  - in_ready = 1 from the first clk after release.
  - Reset mid-load discards the partial grid.
- LOAD:
  - in_ready = 1.
  - '\n' with col > 0: rows++. If first row, cols = col. Otherwise col != cols sets error and goes to DRAIN. col is cleared.
  - '\n' with col == 0 (blank line) ends the grid and goes to DONE.
  - EOT ends the grid and goes to DONE. A partial row with col > 0 is counted as a row, with the same length check.
  - Completing the DEPTH-th row goes to DONE immediately; no terminator is needed.
  - '@' or '.' with col == WIDTH sets error and goes to DRAIN.
  - An illegal byte sets error and goes to DRAIN.
- DRAIN:
  - in_ready = 1; bytes are consumed and discarded.
  - Blank line or EOT goes to DONE with error = 1.
  - The grid holds the cells written before the fault.
- DONE:
  - grid_valid = 1 and in_ready = 0.
  - grid_valid is asserted the cycle after the terminating byte is accepted (latency 1).
  - All outputs are held stable until grid_valid && grid_ready.
  - The cycle after the handshake: state = LOAD; grid_out, rows, cols, paper_count, error and col are all cleared; grid_valid = 0; in_ready = 1.
  - A byte presented in the handshake cycle is not accepted (in_ready = 0).
- Unwritten cells stay 0, both beyond cols and beyond rows.
- Width rules:
  - paper_count cannot overflow: its maximum is WIDTH*DEPTH.
  - col saturates at WIDTH (overflow is caught before the write).
- A grid with zero rows (EOT first) is legal: grid_valid with rows = 0, cols = 0, error = 0.

Decomposition:
- Package grid_pkg:
  - character constants CH_PAPER, CH_EMPTY, CH_NL, CH_CR, CH_EOT
  - state typedef (LOAD, DRAIN, DONE)
  - class typedef (PAPER, EMPTY, NL, CR, EOT, ILLEGAL)
- Sub-module grid_char_classify: combinational, in_data to class.
- The grid register, counters and FSM stay in grid_loader.

Test Plan:
- WIDTH=DEPTH=4, stream "@@.@\n.@@.\n@...\n@@@@\n" with grid_ready=1 -> grid_valid exactly 1 cycle after the final '\n'; rows=4, cols=4, paper_count=10, error=0; row0 bits = 4'b1011, row3 = 4'b1111.
- Stream "@.\n.@\n\n" -> DONE on the blank line; rows=2, cols=2, paper_count=2; all other bits 0.
- Stream "@@@\n@@\n\x04" -> error=1 at grid_valid; rows=1, cols=3; row1 bits[1:0]=2'b11 retained; trailing bytes drained.
- Hold grid_ready=0 for 5 cycles after grid_valid while in_valid=1 -> in_ready=0 and outputs constant throughout. Then one grid_ready pulse -> next cycle all outputs 0, in_ready=1.
- Stream "@x@\n\x04" -> error=1, paper_count=1. Stream "@@@@@\n" with WIDTH=4 -> error=1 on the 5th '@'.
- Deassert rst_n mid-row after "@@" -> outputs immediately 0. After release, "@\n\x04" -> rows=1, cols=1, paper_count=1.
